// File: rtl/mhsa_pkg.sv
// Constants and state encoding shared by the MHSA weight-fetch blocks.
package mhsa_pkg;

    localparam int ROWS          = 128;
    localparam int WORDS_PER_ROW = 16;
    localparam int ROW_W         = 7;
    localparam int WORD_W        = 4;

    typedef enum logic [1:0] {
        WK_IDLE  = 2'd0,
        WK_FETCH = 2'd1,
        WK_DRAIN = 2'd2
    } wk_state_e;

endpackage

// File: rtl/wk_fetch_if.sv
// Control, weight-memory and PE-array signals of the Wk fetcher.
interface wk_fetch_if #(
    parameter int WIDTH = 64
);
    import mhsa_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              mem_write_en;
    logic [31:0]       mem_addr;
    logic [WIDTH-1:0]  mem_data_out;
    logic              w_valid;
    logic              w_ready;
    logic [WIDTH-1:0]  w_data;
    logic [ROW_W-1:0]  w_row;
    logic [WORD_W-1:0] w_word;
    logic              w_last;

    modport master (
        input  start, mem_data_out, w_ready,
        output busy, done, mem_write_en, mem_addr,
               w_valid, w_data, w_row, w_word, w_last
    );

    modport slave (
        output start, mem_data_out, w_ready,
        input  busy, done, mem_write_en, mem_addr,
               w_valid, w_data, w_row, w_word, w_last
    );

endinterface

// File: rtl/wk_skid_fifo.sv
// Two-entry tagged FIFO between weight memory and the PE array; when full it
// still accepts a push in the same cycle as a pop.
module wk_skid_fifo #(
    parameter int DW = 76
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);
    import mhsa_pkg::*;

    logic [DW-1:0] entry_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          wr_en_s;
    logic          rd_en_s;

    assign rd_en_s = pop_i && (count_q != 2'd0);
    assign wr_en_s = push_i && ((count_q != 2'd2) || rd_en_s);

    assign valid_o = (count_q != 2'd0);
    assign head_o  = entry_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries counted as valid are ever read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            entry_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wk_fetch.sv
// Wk weight streamer: walks the matrix in raster order, reads each word from
// weight memory and hands it, tagged with row/word/last, to the PE array.
module wk_fetch #(
    parameter int          WIDTH         = 64,
    parameter logic [31:0] WEIGHT_BASE   = 32'd0,
    parameter int          ROWS          = 128,
    parameter int          WORDS_PER_ROW = 16
) (
    input  logic       clk,
    input  logic       rst,
    wk_fetch_if.master bus
);
    import mhsa_pkg::*;

    localparam int                TAG_W     = WIDTH + ROW_W + WORD_W + 1;
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);

    wk_state_e         state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [31:0]       addr_q, addr_d;
    logic              infl_q, infl_d;
    logic [ROW_W-1:0]  infl_row_q, infl_row_d;
    logic [WORD_W-1:0] infl_word_q, infl_word_d;
    logic              infl_last_q, infl_last_d;
    logic              done_q, done_d;

    logic              last_addr_s;
    logic              pop_s;
    logic              want_issue_s;
    logic              issue_s;
    logic [2:0]        occ_s;
    logic [1:0]        fifo_count_s;
    logic              fifo_valid_s;
    logic [TAG_W-1:0]  fifo_head_s;
    logic [TAG_W-1:0]  fifo_push_data_s;

    assign last_addr_s = (row_q == LAST_ROW) && (word_q == LAST_WORD);
    assign pop_s       = fifo_valid_s && bus.w_ready;

    // Occupancy counts the entry popping this cycle as already free, so the
    // freed slot can be reissued at once and the stream keeps 1 word/cycle.
    assign occ_s        = {1'b0, fifo_count_s} - {2'b00, pop_s} + {2'b00, infl_q};
    assign want_issue_s = (state_q == WK_FETCH) || ((state_q == WK_IDLE) && bus.start);
    assign issue_s      = !rst && want_issue_s && (occ_s < 3'd2);

    assign fifo_push_data_s = {bus.mem_data_out, infl_row_q, infl_word_q, infl_last_q};

    wk_skid_fifo #(
        .DW (TAG_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (infl_q),
        .push_data_i (fifo_push_data_s),
        .pop_i       (pop_s),
        .valid_o     (fifo_valid_s),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s)
    );

    assign bus.w_valid      = fifo_valid_s;
    assign bus.w_data       = fifo_head_s[TAG_W-1 -: WIDTH];
    assign bus.w_row        = fifo_head_s[ROW_W+WORD_W : WORD_W+1];
    assign bus.w_word       = fifo_head_s[WORD_W:1];
    assign bus.w_last       = fifo_head_s[0];
    assign bus.busy         = (state_q != WK_IDLE);
    assign bus.done         = done_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_write_en = 1'b0;

    // Address walk, in-flight tag and FSM next-state.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        word_d      = word_q;
        addr_d      = addr_q;
        infl_d      = issue_s;
        infl_row_d  = infl_row_q;
        infl_word_d = infl_word_q;
        infl_last_d = infl_last_q;
        done_d      = pop_s && bus.w_last;

        if (issue_s) begin
            infl_row_d  = row_q;
            infl_word_d = word_q;
            infl_last_d = last_addr_s;
            if (last_addr_s) begin
                row_d  = {ROW_W{1'b0}};
                word_d = {WORD_W{1'b0}};
                addr_d = WEIGHT_BASE;
            end else if (word_q == LAST_WORD) begin
                row_d  = row_q + ROW_W'(1);
                word_d = {WORD_W{1'b0}};
                addr_d = addr_q + 32'd1;
            end else begin
                word_d = word_q + WORD_W'(1);
                addr_d = addr_q + 32'd1;
            end
        end else begin
            addr_d = addr_q;
        end

        case (state_q)
            WK_IDLE: begin
                if (bus.start) begin
                    state_d = last_addr_s ? WK_DRAIN : WK_FETCH;
                end else begin
                    state_d = WK_IDLE;
                end
            end
            WK_FETCH: begin
                if (issue_s && last_addr_s) begin
                    state_d = WK_DRAIN;
                end else begin
                    state_d = WK_FETCH;
                end
            end
            WK_DRAIN: begin
                if (pop_s && bus.w_last) begin
                    state_d = WK_IDLE;
                end else begin
                    state_d = WK_DRAIN;
                end
            end
            default: state_d = WK_IDLE;
        endcase
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WK_IDLE;
            row_q       <= {ROW_W{1'b0}};
            word_q      <= {WORD_W{1'b0}};
            addr_q      <= WEIGHT_BASE;
            infl_q      <= 1'b0;
            infl_row_q  <= {ROW_W{1'b0}};
            infl_word_q <= {WORD_W{1'b0}};
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            infl_q      <= infl_d;
            infl_row_q  <= infl_row_d;
            infl_word_q <= infl_word_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_wk_fetch.sv
// Directed bench for wk_fetch with a one-cycle-latency weight memory model.
module tb_wk_fetch;

    localparam logic [31:0] WB = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wk_fetch_if #(.WIDTH(64)) bus ();

    wk_fetch #(
        .WIDTH         (64),
        .WEIGHT_BASE   (WB),
        .ROWS          (128),
        .WORDS_PER_ROW (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Wk word for flat index idx; byte 0 (column 8*word) lands in bits [63:56].
    function automatic logic [63:0] exp_word(input int idx);
        logic [63:0] w;
        int row;
        int col;
        w   = 64'd0;
        row = idx / 16;
        for (int b = 0; b < 8; b++) begin
            col = (idx % 16) * 8 + b;
            w   = {w[55:0], 8'((row * 13 + col * 7 + 3) ^ row)};
        end
        return w;
    endfunction

    function automatic logic [63:0] mem_word(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - WB;
        if (off < 32'd2048) return exp_word(int'(off));
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    always @(posedge clk) bus.mem_data_out <= mem_word(bus.mem_addr);

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.w_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_tests++; if (bus.w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid got=%b exp=0", bus.w_valid); end
        n_tests++; if (bus.mem_addr !== WB) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=%h", bus.mem_addr, WB); end
        n_tests++; if (bus.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en got=%b exp=0", bus.mem_write_en); end
        rst = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_stream();
        int idx = 0; int first_c = -1; int last_c = -1; int done_c = -1; int done_n = 0;
        bus.w_ready = 1'b1;
        for (int c = 0; c < 2060; c++) begin
            bus.start = (c == 0);
            @(negedge clk);
            if (bus.done) begin done_n++; done_c = c; end
            if (bus.w_valid) begin
                if (first_c < 0) first_c = c;
                if (bus.w_last) last_c = c;
                n_tests++;
                if (bus.w_row !== 7'(idx / 16) || bus.w_word !== 4'(idx % 16) ||
                    bus.w_data !== exp_word(idx) || bus.w_last !== (idx == 2047)) begin
                    n_fail++;
                    $display("FAIL full_word idx=%0d got row=%0d word=%0d data=%h last=%b exp data=%h",
                             idx, bus.w_row, bus.w_word, bus.w_data, bus.w_last, exp_word(idx));
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (idx !== 2048) begin n_fail++; $display("FAIL full_count got=%0d exp=2048", idx); end
        n_tests++; if (first_c !== 2) begin n_fail++; $display("FAIL full_first_valid got=%0d exp=2", first_c); end
        n_tests++; if (last_c !== 2049) begin n_fail++; $display("FAIL full_last_cycle got=%0d exp=2049", last_c); end
        n_tests++; if (done_c !== 2050 || done_n !== 1) begin n_fail++; $display("FAIL full_done got cycle=%0d pulses=%0d exp 2050/1", done_c, done_n); end
    endtask

    task automatic test_toggle_ready();
        int idx = 0; int issued = 0; int popped = 0; int max_out = 0; int done_c = -1;
        logic [31:0] prev;
        prev = bus.mem_addr;
        for (int c = 0; c < 6000 && done_c < 0; c++) begin
            bus.start   = (c == 0);
            bus.w_ready = (c % 2 == 1);
            @(negedge clk);
            if (bus.mem_addr !== prev) issued++;
            prev = bus.mem_addr;
            if (issued - popped > max_out) max_out = issued - popped;
            if (bus.done) done_c = c;
            if (bus.w_valid && bus.w_ready) begin
                n_tests++;
                if (bus.w_row !== 7'(idx / 16) || bus.w_word !== 4'(idx % 16) || bus.w_data !== exp_word(idx)) begin
                    n_fail++;
                    $display("FAIL toggle_word idx=%0d got row=%0d word=%0d data=%h", idx, bus.w_row, bus.w_word, bus.w_data);
                end
                idx++;
                popped++;
            end
            @(posedge clk); #1;
        end
        bus.w_ready = 1'b1;
        n_tests++; if (done_c < 0) begin n_fail++; $display("FAIL toggle_timeout got=no_done exp=done"); end
        n_tests++; if (idx !== 2048) begin n_fail++; $display("FAIL toggle_count got=%0d exp=2048", idx); end
        n_tests++; if (issued !== 2048) begin n_fail++; $display("FAIL toggle_reads got=%0d exp=2048", issued); end
        n_tests++; if (max_out !== 2) begin n_fail++; $display("FAIL toggle_outstanding got=%0d exp=2", max_out); end
    endtask

    task automatic test_stall();
        int idx = 0; int done_c = -1;
        for (int c = 0; c < 2200 && done_c < 0; c++) begin
            bus.start   = (c == 0);
            bus.w_ready = (c >= 22);
            @(negedge clk);
            if (c >= 2 && c <= 21) begin
                n_tests++;
                if (bus.w_valid !== 1'b1 || bus.w_row !== 7'd0 || bus.w_word !== 4'd0 || bus.w_data !== exp_word(0)) begin
                    n_fail++;
                    $display("FAIL stall_hold c=%0d got valid=%b row=%0d word=%0d data=%h", c, bus.w_valid, bus.w_row, bus.w_word, bus.w_data);
                end
            end
            if (c == 21) begin
                n_tests++; if (bus.mem_addr !== WB + 32'd2) begin n_fail++; $display("FAIL stall_reads got=%h exp=%h", bus.mem_addr, WB + 32'd2); end
            end
            if (bus.done) done_c = c;
            if (bus.w_valid && bus.w_ready) begin
                n_tests++;
                if (bus.w_row !== 7'(idx / 16) || bus.w_word !== 4'(idx % 16) || bus.w_data !== exp_word(idx)) begin
                    n_fail++;
                    $display("FAIL stall_word idx=%0d got row=%0d word=%0d", idx, bus.w_row, bus.w_word);
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (idx !== 2048) begin n_fail++; $display("FAIL stall_count got=%0d exp=2048", idx); end
        n_tests++; if (done_c !== 2070) begin n_fail++; $display("FAIL stall_done got=%0d exp=2070", done_c); end
    endtask

    task automatic test_start_ignored();
        int idx = 0; int done_c = -1; int done_n = 0;
        bus.w_ready = 1'b1;
        for (int c = 0; c < 2060; c++) begin
            bus.start = (c == 0 || c == 502);
            @(negedge clk);
            if (bus.done) begin done_n++; done_c = c; end
            if (bus.w_valid) begin
                n_tests++;
                if (bus.w_row !== 7'(idx / 16) || bus.w_word !== 4'(idx % 16) || bus.w_data !== exp_word(idx)) begin
                    n_fail++;
                    $display("FAIL ignore_word idx=%0d got row=%0d word=%0d", idx, bus.w_row, bus.w_word);
                end
                idx++;
            end
            if (c == 2059) begin
                n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_end got=%b exp=0", bus.busy); end
            end
            @(posedge clk); #1;
        end
        n_tests++; if (idx !== 2048) begin n_fail++; $display("FAIL ignore_count got=%0d exp=2048", idx); end
        n_tests++; if (done_c !== 2050 || done_n !== 1) begin n_fail++; $display("FAIL ignore_done got cycle=%0d pulses=%0d exp 2050/1", done_c, done_n); end
    endtask

    task automatic test_rst_mid();
        int idx = 0;
        bus.w_ready = 1'b1;
        for (int c = 0; c < 1014; c++) begin
            bus.start = (c == 0 || c == 1003 || c == 1006);
            rst = (c == 1003 || c == 1011 || c == 1012);
            @(negedge clk);
            if (c <= 1002 && bus.w_valid) begin
                n_tests++;
                if (bus.w_row !== 7'(idx / 16) || bus.w_word !== 4'(idx % 16)) begin
                    n_fail++;
                    $display("FAIL rst_pre_word idx=%0d got row=%0d word=%0d", idx, bus.w_row, bus.w_word);
                end
                idx++;
            end
            if (c == 1004 || c == 1005) begin
                n_tests++;
                if (bus.w_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_flush c=%0d got valid=%b busy=%b done=%b exp 0/0/0", c, bus.w_valid, bus.busy, bus.done);
                end
            end
            if (c == 1004) begin
                n_tests++; if (bus.mem_addr !== WB) begin n_fail++; $display("FAIL rst_addr got=%h exp=%h", bus.mem_addr, WB); end
            end
            if (c >= 1008 && c <= 1010) begin
                n_tests++;
                if (bus.w_valid !== 1'b1 || bus.w_row !== 7'd0 || bus.w_word !== 4'(c - 1008) || bus.w_data !== exp_word(c - 1008)) begin
                    n_fail++;
                    $display("FAIL rst_restart c=%0d got valid=%b row=%0d word=%0d exp row=0 word=%0d", c, bus.w_valid, bus.w_row, bus.w_word, c - 1008);
                end
            end
            if (c == 1013) begin
                n_tests++; if (bus.busy !== 1'b0 || bus.w_valid !== 1'b0) begin n_fail++; $display("FAIL rst_final got busy=%b valid=%b exp 0/0", bus.busy, bus.w_valid); end
            end
            @(posedge clk); #1;
        end
        n_tests++; if (idx !== 1001) begin n_fail++; $display("FAIL rst_pre_count got=%0d exp=1001", idx); end
    endtask

    task automatic test_back_to_back();
        int idx = 0; int done1 = -1; int done2 = -1; int second_first = -1;
        bus.w_ready = 1'b1;
        for (int c = 0; c < 4106; c++) begin
            bus.start = (c == 0 || c == 2050);
            @(negedge clk);
            if (bus.done) begin
                if (done1 < 0) done1 = c; else done2 = c;
            end
            if (c == 2050 || c == 2051) begin
                n_tests++;
                if (bus.busy !== (c == 2051)) begin n_fail++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, bus.busy, (c == 2051)); end
            end
            if (bus.w_valid) begin
                if (idx == 2048) second_first = c;
                n_tests++;
                if (bus.w_row !== 7'((idx % 2048) / 16) || bus.w_word !== 4'(idx % 16) ||
                    bus.w_data !== exp_word(idx % 2048) || bus.w_last !== ((idx % 2048) == 2047)) begin
                    n_fail++;
                    $display("FAIL b2b_word idx=%0d got row=%0d word=%0d last=%b", idx, bus.w_row, bus.w_word, bus.w_last);
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (idx !== 4096) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4096", idx); end
        n_tests++; if (done1 !== 2050 || done2 !== 4100) begin n_fail++; $display("FAIL b2b_done got=%0d,%0d exp=2050,4100", done1, done2); end
        n_tests++; if (second_first !== 2052) begin n_fail++; $display("FAIL b2b_second_first got=%0d exp=2052", second_first); end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.w_ready = 1'b0;
        test_reset();
        test_full_stream();
        test_toggle_ready();
        test_stall();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wk_fetch.md
WK_FETCH -- requirements
Module: wk_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning weight memory word width in bits.
REQ-002 SHALL have parameter WEIGHT_BASE, default 0, meaning first Wk word address in the weight memory.
REQ-003 SHALL have parameter ROWS, default 128, meaning weight rows per matrix.
REQ-004 SHALL have parameter WORDS_PER_ROW, default 16, meaning memory words per row (128 bytes / 8).
REQ-005 SHALL be decided as follows: one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1 bit: pulse that begins a full-matrix stream.
REQ-009 SHALL have port busy, output, 1 bit: stream in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at end of stream.
REQ-011 SHALL have port mem_write_en, output, 1 bit: constant 0 (read-only master).
REQ-012 SHALL have port mem_addr, output, 32 bits: weight memory read address.
REQ-013 SHALL have port mem_data_out, input, WIDTH bits: memory read data, valid one cycle after the address.
REQ-014 SHALL have port w_valid, output, 1 bit: w_data is valid.
REQ-015 SHALL have port w_ready, input, 1 bit: downstream PE array accepts the word.
REQ-016 SHALL have port w_data, output, WIDTH bits: packed weight word, byte 0 in bits [63:56].
REQ-017 SHALL have port w_row, output, 7 bits: row index of w_data.
REQ-018 SHALL have port w_word, output, 4 bits: word index within the row.
REQ-019 SHALL have port w_last, output, 1 bit: final word of the matrix.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after the last address issues; DRAIN->IDLE on the w_last handshake.
REQ-021 SHALL issue address WEIGHT_BASE + row*WORDS_PER_ROW + word, incrementing word and then row in raster order, ending at WEIGHT_BASE+2047 by default.
REQ-022 SHALL issue at most one read per cycle, and only when (fifo_count + inflight) < 2.
REQ-023 SHALL push mem_data_out, tagged with its row/word/last, into a 2-entry FIFO in the cycle after issue.
REQ-024 SHALL drive w_valid = FIFO non-empty; the head SHALL pop on w_valid && w_ready; w_data/w_row/w_word/w_last SHALL hold stable while w_valid && !w_ready.
REQ-025 SHALL sustain 1 word/cycle with w_ready held high: first w_valid 2 cycles after start, last word 2049 cycles after start (default params).
REQ-026 SHALL allow a simultaneous push and pop on a full FIFO with no loss.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL pulse done for exactly one cycle, in the cycle after the w_last handshake; busy SHALL fall in that same cycle.
REQ-029 SHALL never emit words out of order, duplicate a word, or drop a word under any w_ready pattern.
REQ-030 SHALL allow a new start in the cycle done is high; it begins a fresh stream from row 0.

Reset
REQ-031 SHALL, on rst, return to IDLE, flush the FIFO and in-flight tag, and clear counters.
REQ-032 SHALL drive reset output values: busy=0, done=0, w_valid=0, mem_addr=WEIGHT_BASE, mem_write_en=0.
REQ-033 SHALL, when rst is asserted mid-stream, discard read data returning the following cycle; rst SHALL take priority over start.

Structure
REQ-034 SHALL place the FSM state enum and the WORDS_PER_ROW/ROWS constants in the shared package mhsa_pkg.
REQ-035 SHALL implement the 2-entry tagged FIFO as sub-module wk_skid_fifo.

Verification
REQ-036 SHALL cover: start, w_ready=1 -> 2048 words, w_data matches Wk.txt packing, w_last on word 2047 (row 127, word 15), done at cycle 2050.
REQ-037 SHALL cover: w_ready toggling 1/0 every cycle -> same 2048-word sequence, no gaps in index and no repeats; mem_addr never advances while FIFO + inflight = 2.
REQ-038 SHALL cover: w_ready=0 for 20 cycles after the first valid -> word (0,0) held stable, exactly 2 reads issued.
REQ-039 SHALL cover: start pulsed again at word 500 -> ignored, stream completes normally.
REQ-040 SHALL cover: rst at word 1000 -> next cycle w_valid=0, busy=0; subsequent start restarts at row 0 word 0.
REQ-041 SHALL cover: start in the done cycle -> second full stream begins with no idle gap beyond the 2-cycle latency.
